button_driver: RTL and testbench

BUTTON_DRIVER -- requirements
Module: button_driver

---
 rtl/button_driver.sv | 107 ++++++++++
 tb/tb_button_driver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_driver.sv
`default_nettype none
// ============================================================================
//  Module      : button_driver
//  Description : Presses a toggle-style button until its stateful feedback
//                matches a requested level, retrying up to MAX_ATTEMPTS
//                times, then pulses done (with error if the level was never
//                reached). All outputs are Moore-decoded from state.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_driver #(
  parameter int PRESS_CYCLES   = 1,
  parameter int RELEASE_CYCLES = 1,
  parameter int MAX_ATTEMPTS   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_state,
  output logic req_ready,
  input  logic stateful_button,
  output logic button,
  output logic done,
  output logic error
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_PRESS   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_VERIFY  = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAIL    = 3'd6
  } state_t;

  // Phase counter counts down to zero, so it reloads with length-1.
  localparam logic [7:0] c_press_reload   = 8'(PRESS_CYCLES - 1);
  localparam logic [7:0] c_release_reload = 8'(RELEASE_CYCLES - 1);
  localparam logic [3:0] c_max_attempts   = 4'(MAX_ATTEMPTS);
  localparam logic [3:0] c_attempts_sat   = 4'hF;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_target;
  logic [7:0] r_phase;
  logic [3:0] r_attempts;
  logic       w_accept;
  logic       w_enter_press;
  logic       w_enter_release;

  assign w_accept        = (r_state == ST_IDLE) && req_valid;
  assign w_enter_press   = (w_next_state == ST_PRESS) && (r_state != ST_PRESS);
  assign w_enter_release = (w_next_state == ST_RELEASE) && (r_state != ST_RELEASE);

  // Next-state decode; feedback is compared against the latched target only.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (req_valid) w_next_state = ST_CHECK;
      ST_CHECK:   w_next_state = (stateful_button == r_target) ? ST_DONE : ST_PRESS;
      ST_PRESS:   if (r_phase == 8'd0) w_next_state = ST_RELEASE;
      ST_RELEASE: if (r_phase == 8'd0) w_next_state = ST_VERIFY;
      ST_VERIFY: begin
        if (stateful_button == r_target)       w_next_state = ST_DONE;
        else if (r_attempts < c_max_attempts)  w_next_state = ST_PRESS;
        else                                   w_next_state = ST_FAIL;
      end
      ST_DONE:    w_next_state = ST_IDLE;
      ST_FAIL:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Target latch and attempt counter: cleared on acceptance, bumped per press, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target   <= 1'b0;
      r_attempts <= 4'd0;
    end else if (w_accept) begin
      r_target   <= req_state;
      r_attempts <= 4'd0;
    end else if (w_enter_press && (r_attempts != c_attempts_sat)) begin
      r_attempts <= r_attempts + 4'd1;
    end
  end

  // Phase counter: reloads on PRESS/RELEASE entry, otherwise counts down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_phase <= 8'd0;
    else if (w_enter_press)    r_phase <= c_press_reload;
    else if (w_enter_release)  r_phase <= c_release_reload;
    else if (r_phase != 8'd0)  r_phase <= r_phase - 8'd1;
  end

  assign req_ready = (r_state == ST_IDLE);
  assign button    = (r_state == ST_PRESS);
  assign done      = (r_state == ST_DONE) || (r_state == ST_FAIL);
  assign error     = (r_state == ST_FAIL);

endmodule
`default_nettype wire

// File: tb/tb_button_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_driver
//  Description : Scoreboard bench for button_driver: a default instance and a
//                PRESS_CYCLES=3 / RELEASE_CYCLES=2 instance, each driving a
//                behavioural toggle model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_driver;

  typedef struct {
    int d;
    int lat;
    int err;
    int pulses;
    int high;
    int first;
  } exp_t;

  localparam int c_normal = 0;
  localparam int c_stuck  = 1;
  localparam int c_ignore = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_state;
  logic [1:0] req_ready;
  logic [1:0] fb;
  logic [1:0] button;
  logic [1:0] done;
  logic [1:0] error;

  logic       model_load;
  logic       fb_init;
  int         mode;
  logic [1:0] m_bprev;
  logic [1:0] m_ignored;

  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  int   t0[2];
  int   busy[2];
  int   pulses[2];
  int   high[2];
  int   first[2];
  int   chk_next[2];
  int   acc_cnt[2];
  logic mon_bprev[2];

  button_driver u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_state(req_state[0]),
    .req_ready(req_ready[0]), .stateful_button(fb[0]), .button(button[0]),
    .done(done[0]), .error(error[0])
  );

  button_driver #(.PRESS_CYCLES(3), .RELEASE_CYCLES(2), .MAX_ATTEMPTS(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_state(req_state[1]),
    .req_ready(req_ready[1]), .stateful_button(fb[1]), .button(button[1]),
    .done(done[1]), .error(error[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Toggle-FSM model: reacts to the rising edge of button.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (model_load) begin
        fb[d]        <= fb_init;
        m_ignored[d] <= 1'b0;
      end else if (button[d] && !m_bprev[d]) begin
        if (mode == c_normal) fb[d] <= ~fb[d];
        else if (mode == c_ignore) begin
          if (!m_ignored[d]) m_ignored[d] <= 1'b1;
          else               fb[d] <= ~fb[d];
        end
      end
      m_bprev[d] <= button[d];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks each transaction from acceptance and scores it on done.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        busy[d]     = 0;
        chk_next[d] = 0;
        if (d == 0) sb.delete();
      end else begin
        if (chk_next[d] != 0) begin
          check("ready_after_done", int'(req_ready[d]), 1);
          check("done_one_cycle", int'(done[d]), 0);
          chk_next[d] = 0;
        end
        if (busy[d] != 0 && button[d]) begin
          high[d]++;
          if (!mon_bprev[d]) pulses[d]++;
          if (first[d] < 0) first[d] = cyc - t0[d];
        end
        mon_bprev[d] = button[d];
        if (done[d]) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("dut_id", d, e.d);
            check("latency", cyc - t0[d], e.lat);
            check("error", int'(error[d]), e.err);
            check("pulses", pulses[d], e.pulses);
            check("button_cycles", high[d], e.high);
            check("first_press", first[d], e.first);
          end
          busy[d]     = 0;
          chk_next[d] = 1;
        end
        if (req_valid[d] && req_ready[d]) begin
          t0[d]      = cyc + 1;
          busy[d]    = 1;
          pulses[d]  = 0;
          high[d]    = 0;
          first[d]   = -1;
          acc_cnt[d]++;
        end
      end
    end
  end

  task automatic load(input logic v, input int m);
    @(posedge clk); #1;
    fb_init    = v;
    mode       = m;
    model_load = 1'b1;
    @(posedge clk); #1;
    model_load = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check("timeout_waiting_done", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic run_req(input int d, input logic tgt, input int lat, input int err,
                         input int np, input int nh, input int fst);
    exp_t e;
    e = '{d: d, lat: lat, err: err, pulses: np, high: nh, first: fst};
    @(posedge clk); #1;
    req_state[d] = tgt;
    req_valid[d] = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   a0;
    cyc = 0; checks = 0; errors = 0;
    for (int d = 0; d < 2; d++) begin
      busy[d] = 0; chk_next[d] = 0; acc_cnt[d] = 0; t0[d] = 0;
      pulses[d] = 0; high[d] = 0; first[d] = -1;
    end
    rst_n = 1'b0; req_valid = 2'b00; req_state = 2'b00;
    model_load = 1'b0; fb_init = 1'b0; mode = c_normal;

    #12;
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", int'(req_ready[d]), 1);
      check("reset_button", int'(button[d]), 0);
      check("reset_done", int'(done[d]), 0);
      check("reset_error", int'(error[d]), 0);
    end
    @(posedge clk); #2 rst_n = 1'b1;

    // Single successful press.
    load(1'b0, c_normal); run_req(0, 1'b1, 4, 0, 1, 1, 1);
    // Already at target: no press.
    run_req(0, 1'b1, 1, 0, 0, 0, -1);
    // Feedback stuck: three presses then error.
    load(1'b0, c_stuck);  run_req(0, 1'b1, 10, 1, 3, 3, 1);
    // First press ignored: success on second.
    load(1'b0, c_ignore); run_req(0, 1'b1, 7, 0, 2, 2, 1);
    // Drive toward 0.
    load(1'b1, c_normal); run_req(0, 1'b0, 4, 0, 1, 1, 1);

    // Request held through DONE: second acceptance only after IDLE returns.
    load(1'b0, c_normal);
    e = '{d: 0, lat: 1, err: 0, pulses: 0, high: 0, first: -1};
    @(posedge clk); #1;
    req_state[0] = 1'b0; req_valid[0] = 1'b1;
    sb.push_back(e); sb.push_back(e);
    a0 = acc_cnt[0];
    for (int i = 0; i < 20 && (acc_cnt[0] - a0) < 2; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    drain();

    // Longer press/release timing.
    load(1'b0, c_normal); run_req(1, 1'b1, 7, 0, 1, 3, 1);
    load(1'b1, c_stuck);  run_req(1, 1'b0, 19, 1, 3, 9, 1);

    // Reset during PRESS with the request held.
    load(1'b0, c_normal);
    e = '{d: 0, lat: 4, err: 0, pulses: 1, high: 1, first: 1};
    @(posedge clk); #1;
    req_state[0] = 1'b1; req_valid[0] = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    @(posedge clk); #1;
    check("button_before_reset", int'(button[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    check("reset_mid_button", int'(button[0]), 0);
    check("reset_mid_ready", int'(req_ready[0]), 1);
    check("reset_mid_done", int'(done[0]), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    check("accept_first_edge", int'(req_ready[0]), 0);
    req_valid[0] = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
